// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
// Holds every fetch-stage prediction record in a circular queue until the
// instruction resolves in EX. The head record is then compared with the
// resolved outcome. A mismatch produces a one-cycle flush that carries the
// corrected fetch PC. Every resolved instruction produces one registered
// training beat for the predictor.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   if_valid          fetch pushes {if_pc, if_je, if_jdest}
//   push_ready        queue not full (registered, occupancy after the edge)
//   ex_valid          EX retires one instruction and pops the head record
//   ex_is_jmp         retiring instruction is a branch/jump
//   ex_taken          resolved direction
//   ex_dest           resolved target
//   upd_*             registered training beat (upd_is_jmp is the strobe)
//   flush, flush_pc   one-cycle mispredict redirect
//   stat_branches     saturating count of resolved branches
//   stat_mispred      saturating count of mispredicts
//   err_underflow     sticky, set by a pop on an empty queue
// -----------------------------------------------------------------------------
module branch_resolver #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_je,
  input  logic [ADDR_W-1:0] if_jdest,
  output logic              push_ready,
  input  logic              ex_valid,
  input  logic              ex_is_jmp,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_dest,
  output logic [ADDR_W-1:0] upd_pc,
  output logic              upd_is_jmp,
  output logic [ADDR_W-1:0] upd_dest,
  output logic              upd_res,
  output logic              flush,
  output logic [ADDR_W-1:0] flush_pc,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispred,
  output logic              err_underflow
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STAT_W = 32;

  // Prediction record storage (contents need no reset)
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [ADDR_W-1:0] jdest_mem [DEPTH];
  logic [DEPTH-1:0]  je_mem;

  // Queue state
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              push_ready_q, push_ready_d;

  // Registered outputs
  logic [ADDR_W-1:0] upd_pc_q,     upd_pc_d;
  logic              upd_is_jmp_q, upd_is_jmp_d;
  logic [ADDR_W-1:0] upd_dest_q,   upd_dest_d;
  logic              upd_res_q,    upd_res_d;
  logic              flush_q,      flush_d;
  logic [ADDR_W-1:0] flush_pc_q,   flush_pc_d;
  logic [STAT_W-1:0] stat_br_q,    stat_br_d;
  logic [STAT_W-1:0] stat_mp_q,    stat_mp_d;
  logic              err_q,        err_d;

  // Decode signals
  logic [ADDR_W-1:0] head_pc;
  logic [ADDR_W-1:0] head_jdest;
  logic              head_je;
  logic              q_empty;
  logic              q_full;
  logic              pop_ok;
  logic              pop_empty;
  logic              act_taken;
  logic              mispred;
  logic              push_ok;

  // Head record and pop/push qualification
  always_comb begin
    head_pc    = pc_mem[rd_ptr_q];
    head_jdest = jdest_mem[rd_ptr_q];
    head_je    = je_mem[rd_ptr_q];
    q_empty    = (count_q == '0);
    q_full     = (count_q == CNT_W'(DEPTH));
    pop_ok     = ex_valid && !q_empty;
    pop_empty  = ex_valid && q_empty;
    act_taken  = ex_is_jmp && ex_taken;
    // A wrong direction, or a taken branch to the wrong target, is a mispredict.
    // A set je bit on a non-jump also mismatches here because T is 0.
    mispred    = pop_ok &&
                 ((head_je != act_taken) ||
                  (act_taken && head_je && (head_jdest != ex_dest)));
    // Wrong-path fetch in the mispredict cycle is discarded.
    // Full is judged before the pop, so a pop on a full queue does not admit a push.
    push_ok    = if_valid && !q_full && !mispred;
  end

  // Next-state logic
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    upd_pc_d     = upd_pc_q;
    upd_is_jmp_d = 1'b0;
    upd_dest_d   = upd_dest_q;
    upd_res_d    = upd_res_q;
    flush_d      = 1'b0;
    flush_pc_d   = flush_pc_q;
    stat_br_d    = stat_br_q;
    stat_mp_d    = stat_mp_q;
    err_d        = err_q | pop_empty;

    if (mispred) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    if (pop_ok) begin
      upd_pc_d     = head_pc;
      upd_is_jmp_d = ex_is_jmp;
      upd_dest_d   = ex_dest;
      upd_res_d    = act_taken;
      if (ex_is_jmp && (stat_br_q != '1)) stat_br_d = stat_br_q + STAT_W'(1);
    end

    if (mispred) begin
      flush_d    = 1'b1;
      flush_pc_d = act_taken ? ex_dest : head_pc + ADDR_W'(4);
      if (stat_mp_q != '1) stat_mp_d = stat_mp_q + STAT_W'(1);
    end

    push_ready_d = (count_d != CNT_W'(DEPTH));
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      push_ready_q <= 1'b1;
      upd_pc_q     <= '0;
      upd_is_jmp_q <= 1'b0;
      upd_dest_q   <= '0;
      upd_res_q    <= 1'b0;
      flush_q      <= 1'b0;
      flush_pc_q   <= '0;
      stat_br_q    <= '0;
      stat_mp_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      push_ready_q <= push_ready_d;
      upd_pc_q     <= upd_pc_d;
      upd_is_jmp_q <= upd_is_jmp_d;
      upd_dest_q   <= upd_dest_d;
      upd_res_q    <= upd_res_d;
      flush_q      <= flush_d;
      flush_pc_q   <= flush_pc_d;
      stat_br_q    <= stat_br_d;
      stat_mp_q    <= stat_mp_d;
      err_q        <= err_d;
    end
  end

  // Record storage write
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr_q]    <= if_pc;
      jdest_mem[wr_ptr_q] <= if_jdest;
      je_mem[wr_ptr_q]    <= if_je;
    end
  end

  assign push_ready    = push_ready_q;
  assign upd_pc        = upd_pc_q;
  assign upd_is_jmp    = upd_is_jmp_q;
  assign upd_dest      = upd_dest_q;
  assign upd_res       = upd_res_q;
  assign flush         = flush_q;
  assign flush_pc      = flush_pc_q;
  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
// Scoreboard bench. A queue-based model of the prediction FIFO produces the
// expected training/flush beat when a pop is driven. The beat is compared one
// cycle later, together with push_ready, the statistics and err_underflow.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;

  typedef struct {
    logic [31:0] pc;
    logic        je;
    logic [31:0] jdest;
  } rec_t;

  typedef struct {
    logic [31:0] pc;
    logic        is_jmp;
    logic [31:0] dest;
    logic        res;
    logic        flush;
    logic [31:0] fpc;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic              if_je;
  logic [ADDR_W-1:0] if_jdest;
  logic              push_ready;
  logic              ex_valid;
  logic              ex_is_jmp;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_dest;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_is_jmp;
  logic [ADDR_W-1:0] upd_dest;
  logic              upd_res;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispred;
  logic              err_underflow;

  branch_resolver #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_je         (if_je),
    .if_jdest      (if_jdest),
    .push_ready    (push_ready),
    .ex_valid      (ex_valid),
    .ex_is_jmp     (ex_is_jmp),
    .ex_taken      (ex_taken),
    .ex_dest       (ex_dest),
    .upd_pc        (upd_pc),
    .upd_is_jmp    (upd_is_jmp),
    .upd_dest      (upd_dest),
    .upd_res       (upd_res),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  rec_t        mq[$];
  exp_t        exp_q[$];
  logic [31:0] m_br;
  logic [31:0] m_mp;
  logic        m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_br  = '0;
    m_mp  = '0;
    m_err = 1'b0;
  endtask

  // Drive one cycle of stimulus, update the model, and check after the edge
  task automatic cycle(input logic iv, input logic [31:0] ipc, input logic ije,
                       input logic [31:0] ijd, input logic ev, input logic eisj,
                       input logic etk, input logic [31:0] edst);
    int   size_before;
    logic mis;
    logic t;
    rec_t h;
    rec_t r;
    exp_t e;
    exp_t got;
    @(negedge clk);
    if_valid  = iv;   if_pc = ipc; if_je = ije; if_jdest = ijd;
    ex_valid  = ev;   ex_is_jmp = eisj; ex_taken = etk; ex_dest = edst;

    size_before = mq.size();
    mis = 1'b0;
    if (ev && size_before == 0) m_err = 1'b1;
    if (ev && size_before > 0) begin
      h = mq.pop_front();
      t = eisj && etk;
      mis = (h.je != t) || (t && h.je && (h.jdest != edst));
      e.pc = h.pc; e.is_jmp = eisj; e.dest = edst; e.res = t;
      e.flush = mis; e.fpc = t ? edst : h.pc + 32'd4;
      exp_q.push_back(e);
      if (eisj && m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
      if (mis && m_mp != 32'hFFFF_FFFF)  m_mp = m_mp + 32'd1;
    end
    if (mis) mq.delete();
    if (iv && size_before < int'(DEPTH) && !mis) begin
      r.pc = ipc; r.je = ije; r.jdest = ijd;
      mq.push_back(r);
    end

    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      chk("upd_pc",     64'(upd_pc),     64'(got.pc));
      chk("upd_is_jmp", 64'(upd_is_jmp), 64'(got.is_jmp));
      chk("upd_dest",   64'(upd_dest),   64'(got.dest));
      chk("upd_res",    64'(upd_res),    64'(got.res));
      chk("flush",      64'(flush),      64'(got.flush));
      if (got.flush) chk("flush_pc", 64'(flush_pc), 64'(got.fpc));
    end else begin
      chk("no_beat", 64'(upd_is_jmp), 64'd0);
      chk("no_flush", 64'(flush), 64'd0);
    end
    chk("push_ready",    64'(push_ready),    64'(mq.size() < int'(DEPTH)));
    chk("stat_branches", 64'(stat_branches), 64'(m_br));
    chk("stat_mispred",  64'(stat_mispred),  64'(m_mp));
    chk("err_underflow", 64'(err_underflow), 64'(m_err));
  endtask

  task automatic push(input logic [31:0] pc, input logic je, input logic [31:0] jd);
    cycle(1'b1, pc, je, jd, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic pop(input logic isj, input logic tk, input logic [31:0] dst);
    cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, isj, tk, dst);
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_push_ready"}, 64'(push_ready),    64'd1);
    chk({tag, "_upd_pc"},     64'(upd_pc),        64'd0);
    chk({tag, "_upd_is_jmp"}, 64'(upd_is_jmp),    64'd0);
    chk({tag, "_upd_dest"},   64'(upd_dest),      64'd0);
    chk({tag, "_upd_res"},    64'(upd_res),       64'd0);
    chk({tag, "_flush"},      64'(flush),         64'd0);
    chk({tag, "_flush_pc"},   64'(flush_pc),      64'd0);
    chk({tag, "_stat_br"},    64'(stat_branches), 64'd0);
    chk({tag, "_stat_mp"},    64'(stat_mispred),  64'd0);
    chk({tag, "_err"},        64'(err_underflow), 64'd0);
  endtask

  initial begin
    logic        rv;
    logic        ev;
    logic        isj;
    logic        tk;
    logic [31:0] dst;
    logic [31:0] rpc;
    logic        rje;
    logic [31:0] rjd;
    rec_t        hd;

    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst_n = 1'b0;
    if_valid = 1'b0; if_pc = '0; if_je = 1'b0; if_jdest = '0;
    ex_valid = 1'b0; ex_is_jmp = 1'b0; ex_taken = 1'b0; ex_dest = '0;
    #7;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Correct predictions
    push(32'h100, 1'b0, 32'h0);
    push(32'h104, 1'b1, 32'h200);
    pop(1'b0, 1'b0, 32'h0);
    pop(1'b1, 1'b1, 32'h200);
    idle();

    // Wrong target
    push(32'h40, 1'b1, 32'h300);
    pop(1'b1, 1'b1, 32'h380);
    idle();

    // Full and wrap: fill, drop a fifth push, then alternate pop/push
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 4), 1'b0, 32'h0);
    push(32'h2000, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) pop(1'b0, 1'b0, 32'h0);
      else            push(32'h3000 + 32'(i * 4), 1'b0, 32'h0);
    end
    // Simultaneous push and pop on a full queue, then on a non-full queue
    cycle(1'b1, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 32'h4004, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    while (mq.size() > 0) pop(1'b0, 1'b0, 32'h0);

    // Single entry: pop the lone entry while pushing a new one
    push(32'h500, 1'b0, 32'h0);
    cycle(1'b1, 32'h504, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    pop(1'b0, 1'b0, 32'h0);

    // Aliased prediction: je=1 on a non-jump
    push(32'h600, 1'b1, 32'h700);
    pop(1'b0, 1'b0, 32'h0);
    idle();

    // Random traffic with mostly correct outcomes
    for (int i = 0; i < 80; i++) begin
      rv  = 1'($urandom_range(0, 1));
      rpc = 32'($urandom) & 32'hFFFF_FFFC;
      rje = 1'($urandom_range(0, 1));
      rjd = 32'($urandom) & 32'hFFFF_FFFC;
      ev = 1'b0; isj = 1'b0; tk = 1'b0; dst = 32'h0;
      if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
        hd  = mq[0];
        ev  = 1'b1;
        isj = hd.je ? 1'b1 : 1'($urandom_range(0, 1));
        tk  = hd.je;
        dst = hd.je ? hd.jdest : rjd;
        if ($urandom_range(0, 7) == 0) tk = ~tk;
        if ($urandom_range(0, 7) == 0) dst = dst ^ 32'h10;
      end
      cycle(rv, rpc, rje, rjd, ev, isj, tk, dst);
    end
    while (mq.size() > 0) begin
      hd = mq[0];
      pop(hd.je, hd.je, hd.jdest);
    end

    // Not-taken mispredict with a concurrent wrong-path push, then the
    // back-to-back pop on the cleared queue raises err_underflow
    push(32'h104, 1'b1, 32'h200);
    push(32'h108, 1'b0, 32'h0);
    cycle(1'b1, 32'h10C, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
    pop(1'b0, 1'b0, 32'h0);
    pop(1'b0, 1'b0, 32'h0);
    idle();

    // Asynchronous reset while flush is high
    push(32'h800, 1'b1, 32'h900);
    pop(1'b1, 1'b0, 32'h0);
    chk("flush_before_reset", 64'(flush), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    if_valid = 1'b0; ex_valid = 1'b0;
    rst_n = 1'b1;

    // First push right after release is accepted
    push(32'hA00, 1'b1, 32'hB00);
    pop(1'b1, 1'b1, 32'hB00);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
